// File: rtl/alu_accum_seq.sv
// ---------------------------------------------------------------------------
// alu_accum_seq
//
// Purpose:
//   Sequential ALU with a single accumulator. An operation is accepted with
//   an in_valid/in_ready handshake. Operand A is either num1 or the current
//   accumulator, and operand B is num2. Logic ops, ADD, SUB and PASS finish
//   one cycle after accept. MULT is a shift-add multiplier that handles one
//   multiplier bit per cycle and finishes WIDTH cycles after accept.
//   When an operation finishes, its result goes into the accumulator and
//   out_valid pulses for one cycle. An op that overflows sets the sticky
//   overflow flag and parks the FSM in RUN_ERROR until err_clr is asserted.
//
// Configuration macro:
//   ALU_SATURATE_EN - when defined, an overflowing ADD/MULT result clamps to
//                     all-ones and a SUB underflow clamps to zero. The
//                     overflow flag and the entry into RUN_ERROR behave the
//                     same with or without this macro.
//
// Ports:
//   clk        in   rising-edge clock for all state
//   rst        in   synchronous reset, active low
//   on         in   power enable; 0 steers the FSM toward OFF
//   in_valid   in   operation request strobe
//   in_ready   out  an operation can be accepted this cycle
//   op         in   000 AND, 001 OR, 010 NOT, 011 XOR,
//                   100 ADD, 101 SUB, 110 MULT, 111 PASS
//   load       in   1: A = num1, 0: A = accumulator
//   num1       in   WIDTH-bit load operand
//   num2       in   WIDTH-bit operand B
//   err_clr    in   clears the error state while in RUN_ERROR
//   out_valid  out  one-cycle pulse after a result is written
//   outputVal  out  accumulator contents
//   overflow   out  sticky overflow flag
//   state      out  current FSM state
//   next       out  combinational next FSM state
// ---------------------------------------------------------------------------
module alu_accum_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             on,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             load,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    input  logic             err_clr,
    output logic             out_valid,
    output logic [WIDTH-1:0] outputVal,
    output logic             overflow,
    output logic [1:0]       state,
    output logic [1:0]       next
);

    typedef enum logic [1:0] {
        S_OFF       = 2'b00,
        S_READY     = 2'b01,
        S_RUN       = 2'b10,
        S_RUN_ERROR = 2'b11
    } state_t;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_NOT  = 3'b010;
    localparam logic [2:0] OP_XOR  = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;
    localparam logic [2:0] OP_MULT = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t               r_state;
    logic [WIDTH-1:0]     r_acc;
    logic                 r_overflow;
    logic                 r_outValid;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [2:0]           r_op;
    logic [CW-1:0]        r_count;
    logic [2*WIDTH-1:0]   r_prod;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;

    state_t               w_next;
    logic                 w_accept;
    logic                 w_done;
    logic [WIDTH-1:0]     w_opA;
    logic [WIDTH:0]       w_sum;
    logic [WIDTH-1:0]     w_diff;
    logic [2*WIDTH-1:0]   w_prodNext;
    logic [WIDTH-1:0]     w_result;
    logic                 w_ovf;

    assign in_ready  = rst && (r_state == S_READY) && on;
    assign w_accept  = in_ready && in_valid;
    assign w_opA     = load ? num1 : r_acc;

    assign w_sum      = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff     = r_a - r_b;
    assign w_prodNext = r_prod + (r_mplier[0] ? r_mcand : '0);

    // An op is finished on its first RUN cycle, except MULT. MULT finishes
    // once the last multiplier bit has been folded into the product.
    assign w_done = (r_state == S_RUN) &&
                    ((r_op != OP_MULT) || (r_count == CW'(WIDTH - 1)));

    assign state     = r_state;
    assign next      = w_next;
    assign outputVal = r_acc;
    assign overflow  = r_overflow;
    assign out_valid = r_outValid;

    // Result and overflow for the op in flight. For MULT, the value is the
    // product that includes the final partial term, so it is valid in the
    // same cycle that w_done rises.
    always_comb begin
        w_result = '0;
        w_ovf    = 1'b0;
        case (r_op)
            OP_AND:  w_result = r_a & r_b;
            OP_OR:   w_result = r_a | r_b;
            OP_NOT:  w_result = ~r_a;
            OP_XOR:  w_result = r_a ^ r_b;
            OP_ADD: begin
                w_result = w_sum[WIDTH-1:0];
                w_ovf    = w_sum[WIDTH];
`ifdef ALU_SATURATE_EN
                if (w_sum[WIDTH]) begin
                    w_result = '1;
                end
`endif
            end
            OP_SUB: begin
                w_result = w_diff;
                w_ovf    = (r_a < r_b);
`ifdef ALU_SATURATE_EN
                if (r_a < r_b) begin
                    w_result = '0;
                end
`endif
            end
            OP_MULT: begin
                w_result = w_prodNext[WIDTH-1:0];
                w_ovf    = |w_prodNext[2*WIDTH-1:WIDTH];
`ifdef ALU_SATURATE_EN
                if (|w_prodNext[2*WIDTH-1:WIDTH]) begin
                    w_result = '1;
                end
`endif
            end
            OP_PASS: w_result = r_a;
            default: w_result = r_a;
        endcase
    end

    // Next-state decode. Reset always wins. In RUN_ERROR, err_clr takes
    // priority over dropping 'on'. Dropping 'on' during RUN does not abort
    // the op; it only affects where the FSM goes once the op finishes.
    always_comb begin
        w_next = r_state;
        if (!rst) begin
            w_next = S_OFF;
        end else begin
            case (r_state)
                S_OFF: begin
                    w_next = on ? S_READY : S_OFF;
                end
                S_READY: begin
                    if (!on) begin
                        w_next = S_OFF;
                    end else if (in_valid) begin
                        w_next = S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_done) begin
                        if (w_ovf) begin
                            w_next = S_RUN_ERROR;
                        end else if (!on) begin
                            w_next = S_OFF;
                        end else begin
                            w_next = S_READY;
                        end
                    end
                end
                S_RUN_ERROR: begin
                    if (err_clr) begin
                        w_next = S_READY;
                    end else if (!on) begin
                        w_next = S_OFF;
                    end
                end
                default: w_next = S_OFF;
            endcase
        end
    end

    // All state lives here. On accept, the operands are captured and the
    // multiplier sequencer is primed. While MULT is in RUN, the multiplicand
    // shifts left, the multiplier shifts right, and one partial term is added
    // per cycle. The accumulator changes only on completion. The overflow
    // flag is cleared only when err_clr is asserted in RUN_ERROR.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_OFF;
            r_acc      <= '0;
            r_overflow <= 1'b0;
            r_outValid <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_op       <= OP_AND;
            r_count    <= '0;
            r_prod     <= '0;
            r_mcand    <= '0;
            r_mplier   <= '0;
        end else begin
            r_state    <= w_next;
            r_outValid <= w_done;
            if (w_accept) begin
                r_a      <= w_opA;
                r_b      <= num2;
                r_op     <= op;
                r_count  <= '0;
                r_prod   <= '0;
                r_mcand  <= {{WIDTH{1'b0}}, w_opA};
                r_mplier <= num2;
            end
            if ((r_state == S_RUN) && (r_op == OP_MULT)) begin
                r_prod   <= w_prodNext;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_count  <= r_count + 1'b1;
            end
            if (w_done) begin
                r_acc <= w_result;
                if (w_ovf) begin
                    r_overflow <= 1'b1;
                end
            end
            if ((r_state == S_RUN_ERROR) && err_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_accum_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_accum_seq
//
// Self-checking bench for alu_accum_seq at WIDTH=8. Inputs are driven and
// outputs are sampled on the falling edge of the clock.
// ---------------------------------------------------------------------------
module tb_alu_accum_seq;

    localparam int W = 8;
`ifdef ALU_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         on;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic         load;
    logic [W-1:0] num1;
    logic [W-1:0] num2;
    logic         err_clr;
    logic         out_valid;
    logic [W-1:0] outputVal;
    logic         overflow;
    logic [1:0]   state;
    logic [1:0]   next;

    int   total = 0;
    int   bad   = 0;
    logic [7:0] modelAcc;
    bit   modelOvf;

    typedef struct {
        bit         ld;
        logic [7:0] n1;
        logic [7:0] n2;
        logic [2:0] o;
        logic [7:0] expWrap;
        logic [7:0] expSat;
        bit         expOvf;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    alu_accum_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .on        (on),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .load      (load),
        .num1      (num1),
        .num2      (num2),
        .err_clr   (err_clr),
        .out_valid (out_valid),
        .outputVal (outputVal),
        .overflow  (overflow),
        .state     (state),
        .next      (next)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Stops a hung run so that it fails instead of waiting forever.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Reference behaviour written from the operation definitions. It uses
    // plain integer arithmetic on 8-bit unsigned values.
    function automatic void refModel(input logic [2:0] o, input int a, input int b,
                                     output int res, output bit ovf);
        int full;
        full = 0;
        ovf  = 1'b0;
        res  = 0;
        case (o)
            3'd0: res = a & b;
            3'd1: res = a | b;
            3'd2: res = 255 - a;
            3'd3: res = a ^ b;
            3'd4: begin
                full = a + b;
                ovf  = (full > 255);
                res  = ovf ? (SAT ? 255 : full - 256) : full;
            end
            3'd5: begin
                ovf = (a < b);
                res = ovf ? (SAT ? 0 : a - b + 256) : a - b;
            end
            3'd6: begin
                full = a * b;
                ovf  = (full > 255);
                res  = ovf ? (SAT ? 255 : full % 256) : full;
            end
            default: res = a;
        endcase
    endfunction

    // Waits (with a bound) for in_ready, then presents one op for exactly one
    // accepting edge.
    task automatic acceptOp(input bit ld, input logic [7:0] n1, input logic [7:0] n2,
                            input logic [2:0] o);
        int w;
        w = 0;
        while (in_ready !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        checkOutput("accept ready", 32'(in_ready), 32'd1);
        load     = ld;
        num1     = n1;
        num2     = n2;
        op       = o;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Counts cycles from accept to the out_valid pulse, checking that the
    // block refuses new work while busy.
    task automatic waitDone(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            checkOutput("busy in_ready", 32'(in_ready), 32'd0);
            tick();
            lat++;
        end
    endtask

    task automatic applyStimulus(input bit ld, input logic [7:0] n1, input logic [7:0] n2,
                                 input logic [2:0] o, output int lat);
        acceptOp(ld, n1, n2, o);
        waitDone(lat);
    endtask

    task automatic runOp(input string name, input bit ld, input logic [7:0] n1,
                         input logic [7:0] n2, input logic [2:0] o,
                         input logic [7:0] expOut, input bit expOvf, input bit autoClear);
        int lat;
        logic [1:0] expState;
        applyStimulus(ld, n1, n2, o, lat);
        checkOutput({name, " latency"}, 32'(lat), (o == 3'd6) ? 32'd8 : 32'd1);
        modelAcc = expOut;
        modelOvf = modelOvf | expOvf;
        expState = expOvf ? 2'b11 : (on ? 2'b01 : 2'b00);
        checkOutput({name, " result"}, 32'(outputVal), 32'(expOut));
        checkOutput({name, " overflow"}, 32'(overflow), 32'(modelOvf));
        checkOutput({name, " state"}, 32'(state), 32'(expState));
        tick();
        checkOutput({name, " pulse width"}, 32'(out_valid), 32'd0);
        if (expOvf && autoClear) begin
            err_clr = 1'b1;
            tick();
            err_clr = 1'b0;
            modelOvf = 1'b0;
            checkOutput({name, " clr state"}, 32'(state), 32'd1);
            checkOutput({name, " clr overflow"}, 32'(overflow), 32'd0);
        end
    endtask

    initial begin
        int lat;
        int res;
        bit ovf;
        bit ld;
        logic [7:0] n1;
        logic [7:0] n2;
        logic [2:0] o;

        vecs[0]  = '{1'b1, 8'h0F, 8'hF0, 3'd4, 8'hFF, 8'hFF, 1'b0};
        vecs[1]  = '{1'b0, 8'h00, 8'h01, 3'd4, 8'h00, 8'hFF, 1'b1};
        vecs[2]  = '{1'b1, 8'h0C, 8'h0A, 3'd6, 8'h78, 8'h78, 1'b0};
        vecs[3]  = '{1'b1, 8'h05, 8'h07, 3'd5, 8'hFE, 8'h00, 1'b1};
        vecs[4]  = '{1'b1, 8'hCA, 8'h0F, 3'd0, 8'h0A, 8'h0A, 1'b0};
        vecs[5]  = '{1'b0, 8'h00, 8'h50, 3'd1, 8'h5A, 8'h5A, 1'b0};
        vecs[6]  = '{1'b0, 8'h00, 8'h00, 3'd2, 8'hA5, 8'hA5, 1'b0};
        vecs[7]  = '{1'b0, 8'h00, 8'hFF, 3'd3, 8'h5A, 8'h5A, 1'b0};
        vecs[8]  = '{1'b1, 8'h55, 8'h00, 3'd7, 8'h55, 8'h55, 1'b0};
        vecs[9]  = '{1'b1, 8'h20, 8'h10, 3'd6, 8'h00, 8'hFF, 1'b1};
        vecs[10] = '{1'b1, 8'h80, 8'h80, 3'd4, 8'h00, 8'hFF, 1'b1};
        vecs[11] = '{1'b1, 8'h07, 8'h07, 3'd5, 8'h00, 8'h00, 1'b0};
        vecs[12] = '{1'b1, 8'hFF, 8'hFF, 3'd6, 8'h01, 8'hFF, 1'b1};
        vecs[13] = '{1'b1, 8'h10, 8'h0F, 3'd6, 8'hF0, 8'hF0, 1'b0};
        vecs[14] = '{1'b0, 8'h00, 8'h01, 3'd6, 8'hF0, 8'hF0, 1'b0};
        vecs[15] = '{1'b1, 8'hFF, 8'h00, 3'd4, 8'hFF, 8'hFF, 1'b0};
        vecs[16] = '{1'b1, 8'h00, 8'h01, 3'd5, 8'hFF, 8'h00, 1'b1};

        rst = 1'b0; on = 1'b1; in_valid = 1'b0; op = 3'd0; load = 1'b0;
        num1 = '0; num2 = '0; err_clr = 1'b0;
        modelAcc = 8'h00; modelOvf = 1'b0;

        $display("[TB] reset");
        tick(); tick();
        checkOutput("reset state", 32'(state), 32'd0);
        checkOutput("reset next", 32'(next), 32'd0);
        checkOutput("reset outputVal", 32'(outputVal), 32'd0);
        checkOutput("reset overflow", 32'(overflow), 32'd0);
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset in_ready", 32'(in_ready), 32'd0);
        rst = 1'b1;
        checkOutput("off next", 32'(next), 32'd1);
        tick();
        checkOutput("power-up state", 32'(state), 32'd1);
        checkOutput("power-up in_ready", 32'(in_ready), 32'd1);

        $display("[TB] directed vector table");
        for (int i = 0; i < NV; i++) begin
            runOp($sformatf("vec%0d", i), vecs[i].ld, vecs[i].n1, vecs[i].n2, vecs[i].o,
                  SAT ? vecs[i].expSat : vecs[i].expWrap, vecs[i].expOvf, 1'b1);
        end

        $display("[TB] in_valid ignored while busy");
        acceptOp(1'b1, 8'h03, 8'h05, 3'd6);
        for (int i = 0; i < 8; i++) begin
            in_valid = (i >= 1 && i <= 4);
            load = 1'b1; num1 = 8'h33; op = 3'd7;
            checkOutput("busy out_valid", 32'(out_valid), 32'd0);
            checkOutput("busy ready", 32'(in_ready), 32'd0);
            tick();
        end
        in_valid = 1'b0;
        checkOutput("busy done", 32'(out_valid), 32'd1);
        checkOutput("busy result", 32'(outputVal), 32'h0F);
        modelAcc = 8'h0F;
        tick();

        $display("[TB] on dropped during MULT");
        acceptOp(1'b1, 8'h0C, 8'h0A, 3'd6);
        on = 1'b0;
        waitDone(lat);
        checkOutput("offrun latency", 32'(lat), 32'd8);
        checkOutput("offrun result", 32'(outputVal), 32'h78);
        checkOutput("offrun state", 32'(state), 32'd0);
        modelAcc = 8'h78;
        on = 1'b1;
        tick();
        checkOutput("offrun resume", 32'(state), 32'd1);

        $display("[TB] sticky overflow");
        runOp("stk add", 1'b1, 8'h80, 8'h80, 3'd4, SAT ? 8'hFF : 8'h00, 1'b1, 1'b0);
        on = 1'b0;
        checkOutput("stk next off", 32'(next), 32'd0);
        tick();
        checkOutput("stk off state", 32'(state), 32'd0);
        checkOutput("stk off overflow", 32'(overflow), 32'd1);
        on = 1'b1;
        tick();
        checkOutput("stk ready state", 32'(state), 32'd1);
        checkOutput("stk ready overflow", 32'(overflow), 32'd1);
        runOp("stk keep", 1'b1, 8'h03, 8'h04, 3'd4, 8'h07, 1'b0, 1'b1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checkOutput("stk clr in ready", 32'(overflow), 32'd1);
        runOp("stk clr", 1'b1, 8'h01, 8'h02, 3'd5, SAT ? 8'h00 : 8'hFF, 1'b1, 1'b1);

        $display("[TB] requests while OFF");
        on = 1'b0;
        tick();
        checkOutput("off entry", 32'(state), 32'd0);
        load = 1'b1; num1 = 8'h55; op = 3'd7; in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            checkOutput("off in_ready", 32'(in_ready), 32'd0);
            checkOutput("off state", 32'(state), 32'd0);
            checkOutput("off out_valid", 32'(out_valid), 32'd0);
            checkOutput("off outputVal", 32'(outputVal), 32'(modelAcc));
            tick();
        end
        in_valid = 1'b0;
        on = 1'b1;
        tick();
        checkOutput("off exit", 32'(state), 32'd1);

        $display("[TB] reset during MULT");
        acceptOp(1'b1, 8'h0C, 8'h0A, 3'd6);
        tick(); tick(); tick();
        rst = 1'b0;
        checkOutput("midrst next", 32'(next), 32'd0);
        tick();
        checkOutput("midrst state", 32'(state), 32'd0);
        checkOutput("midrst outputVal", 32'(outputVal), 32'd0);
        checkOutput("midrst overflow", 32'(overflow), 32'd0);
        checkOutput("midrst in_ready", 32'(in_ready), 32'd0);
        rst = 1'b1;
        modelAcc = 8'h00;
        modelOvf = 1'b0;
        for (int i = 0; i < 16; i++) begin
            checkOutput("midrst no pulse", 32'(out_valid), 32'd0);
            tick();
        end
        checkOutput("midrst acc held", 32'(outputVal), 32'd0);

        $display("[TB] randomized ops");
        for (int i = 0; i < 150; i++) begin
            ld = 1'($urandom_range(0, 1));
            n1 = 8'($urandom_range(0, 255));
            n2 = 8'($urandom_range(0, 255));
            o  = 3'($urandom_range(0, 7));
            refModel(o, ld ? int'(n1) : int'(modelAcc), int'(n2), res, ovf);
            runOp($sformatf("rnd%0d", i), ld, n1, n2, o, 8'(res), ovf, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
